// File: rtl/pps_pulse_shaper.sv
`default_nettype none
// ============================================================================
// Module   : pps_pulse_shaper
// Purpose  : Shapes the 1-cycle period tick into a PPS pulse of fixed width with
//            an optional phase delay. The PPS_WATCHDOG_EN macro adds the lost-tick
//            watchdog (o_tick_lost and TIMEOUT_CYC).
// Revision : 1.0 - initial release
// ============================================================================
module pps_pulse_shaper #(
    parameter int CLK_FREQ = 25,
    parameter int WIDTH_US = 70,
    parameter int DELAY_US = 0,
    parameter int CNT_W    = 32
`ifdef PPS_WATCHDOG_EN
    ,
    parameter int TIMEOUT_CYC = 25_000_100
`endif
) (
    input  logic             i_clk_25MHz,
    input  logic             i_rst,
    input  logic             i_tick,
    input  logic             i_en,
    output logic             o_pps,
    output logic             o_busy,
    output logic             o_overrun,
    output logic [CNT_W-1:0] o_pulse_count
`ifdef PPS_WATCHDOG_EN
    ,
    output logic             o_tick_lost
`endif
);

    localparam int c_WIDTH_CYC = WIDTH_US * CLK_FREQ;
    localparam int c_DELAY_CYC = DELAY_US * CLK_FREQ;
    localparam int c_MAX_CYC   = (c_WIDTH_CYC > c_DELAY_CYC) ? c_WIDTH_CYC : c_DELAY_CYC;
    localparam int c_CW        = $clog2(c_MAX_CYC) + 1;
    localparam bit c_HAS_DELAY = (DELAY_US > 0);

    localparam logic [c_CW-1:0]  c_WIDTH_LOAD = c_CW'(c_WIDTH_CYC - 1);
    localparam logic [c_CW-1:0]  c_DELAY_LOAD = c_HAS_DELAY ? c_CW'(c_DELAY_CYC - 1) : '0;
    localparam logic [c_CW-1:0]  c_CYC_ONE    = {{(c_CW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_PULSE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [c_CW-1:0]    r_cnt;
    logic [c_CW-1:0]    w_next_cnt;
    logic               r_pps;
    logic               r_busy;
    logic               r_overrun;
    logic [CNT_W-1:0]   r_pulse_count;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (i_tick && i_en) begin
                    if (c_HAS_DELAY) begin
                        w_next_state = S_DELAY;
                        w_next_cnt   = c_DELAY_LOAD;
                    end else begin
                        w_next_state = S_PULSE;
                        w_next_cnt   = c_WIDTH_LOAD;
                    end
                end
            end
            S_DELAY: begin
                if (r_cnt == '0) begin
                    w_next_state = S_PULSE;
                    w_next_cnt   = c_WIDTH_LOAD;
                end else begin
                    w_next_cnt   = r_cnt - c_CYC_ONE;
                end
            end
            S_PULSE: begin
                if (r_cnt == '0) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_cnt   = r_cnt - c_CYC_ONE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state itself.
    always_ff @(posedge i_clk_25MHz) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_pps         <= 1'b0;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
            r_pulse_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_pps   <= (w_next_state == S_PULSE);
            r_busy  <= (w_next_state != S_IDLE);
            if ((w_next_state == S_PULSE) && (r_state != S_PULSE)) begin
                r_pulse_count <= r_pulse_count + c_CNT_ONE;
            end
            if (i_tick && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_pps         = r_pps;
    assign o_busy        = r_busy;
    assign o_overrun     = r_overrun;
    assign o_pulse_count = r_pulse_count;

`ifdef PPS_WATCHDOG_EN
    localparam int                c_WD_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_WD_W-1:0] c_WD_LIMIT = c_WD_W'(TIMEOUT_CYC);
    localparam logic [c_WD_W-1:0] c_WD_ONE   = {{(c_WD_W-1){1'b0}}, 1'b1};

    logic [c_WD_W-1:0] r_wd_cnt;
    logic              r_tick_lost;

    // Counter saturates at the limit so the flag holds until the next tick.
    always_ff @(posedge i_clk_25MHz) begin
        if (i_rst) begin
            r_wd_cnt    <= '0;
            r_tick_lost <= 1'b0;
        end else begin
            if (i_tick || !i_en) begin
                r_wd_cnt <= '0;
            end else if (r_wd_cnt != c_WD_LIMIT) begin
                r_wd_cnt <= r_wd_cnt + c_WD_ONE;
            end
            if (i_tick) begin
                r_tick_lost <= 1'b0;
            end else if (r_wd_cnt == c_WD_LIMIT) begin
                r_tick_lost <= 1'b1;
            end
        end
    end

    assign o_tick_lost = r_tick_lost;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pps_pulse_shaper.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pps_pulse_shaper
// Purpose  : Random tick/enable/reset stimulus against a cycle-window model of
//            the PPS shaper; two instances cover zero and non-zero delay.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pps_pulse_shaper;

    localparam int c_CLK_FREQ = 25;
    localparam int c_WIDTH_US = 2;
    localparam int c_WCYC     = c_WIDTH_US * c_CLK_FREQ;
    localparam int c_NCYC     = 8000;
    localparam int c_NONE     = -1000000;
    localparam int c_TIMEOUT  = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        en;

    logic        pps0, busy0, ovr0;
    logic [31:0] cnt0;
    logic        pps1, busy1, ovr1;
    logic [3:0]  cnt1;
`ifdef PPS_WATCHDOG_EN
    logic        lost0, lost1;
`endif

    always #20 clk = ~clk;

    pps_pulse_shaper #(
        .CLK_FREQ (c_CLK_FREQ),
        .WIDTH_US (c_WIDTH_US),
        .DELAY_US (0),
        .CNT_W    (32)
`ifdef PPS_WATCHDOG_EN
        ,.TIMEOUT_CYC (c_TIMEOUT)
`endif
    ) dut0 (
        .i_clk_25MHz   (clk),
        .i_rst         (rst),
        .i_tick        (tick),
        .i_en          (en),
        .o_pps         (pps0),
        .o_busy        (busy0),
        .o_overrun     (ovr0),
        .o_pulse_count (cnt0)
`ifdef PPS_WATCHDOG_EN
        ,.o_tick_lost  (lost0)
`endif
    );

    pps_pulse_shaper #(
        .CLK_FREQ (c_CLK_FREQ),
        .WIDTH_US (c_WIDTH_US),
        .DELAY_US (1),
        .CNT_W    (4)
`ifdef PPS_WATCHDOG_EN
        ,.TIMEOUT_CYC (c_TIMEOUT)
`endif
    ) dut1 (
        .i_clk_25MHz   (clk),
        .i_rst         (rst),
        .i_tick        (tick),
        .i_en          (en),
        .o_pps         (pps1),
        .o_busy        (busy1),
        .o_overrun     (ovr1),
        .o_pulse_count (cnt1)
`ifdef PPS_WATCHDOG_EN
        ,.o_tick_lost  (lost1)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input longint act, input longint exp, input int cyc);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, act, exp);
        end
    endtask

    // Model: each instance remembers the cycle of its last accepted tick; every
    // output follows from that cycle, the delay and the width.
    int m_acc [2];
    int m_cnt [2];
    bit m_ovr [2];

    function automatic int dly(input int k);
        return (k == 0) ? 0 : c_CLK_FREQ;
    endfunction

    function automatic bit busy_at(input int k, input int c);
        return (c >= m_acc[k] + 1) && (c <= m_acc[k] + dly(k) + c_WCYC);
    endfunction

    function automatic bit pps_at(input int k, input int c);
        return (c >= m_acc[k] + dly(k) + 1) && (c <= m_acc[k] + dly(k) + c_WCYC);
    endfunction

    initial begin
        int  end0, end1;
`ifdef PPS_WATCHDOG_EN
        int  wd_lc   = 0;
        bit  wd_lost = 1'b0;
`endif
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = c_NONE;
            m_cnt[k] = 0;
            m_ovr[k] = 1'b0;
        end
        rst  = 1'b1;
        tick = 1'b0;
        en   = 1'b1;

        for (int n = 1; n <= c_NCYC; n++) begin
            @(posedge clk);
            #1;
            // Apply the inputs that were sampled on this edge (driven in cycle n-1).
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    m_acc[k] = c_NONE;
                    m_cnt[k] = 0;
                    m_ovr[k] = 1'b0;
                end else begin
                    if (tick) begin
                        if (busy_at(k, n - 1)) m_ovr[k] = 1'b1;
                        else if (en)           m_acc[k] = n - 1;
                    end
                    if (n == m_acc[k] + dly(k) + 1) m_cnt[k] = m_cnt[k] + 1;
                end
            end
`ifdef PPS_WATCHDOG_EN
            if (rst || tick) begin
                wd_lost = 1'b0;
                wd_lc   = n - 1;
            end else begin
                if ((n - 1) - wd_lc - 1 >= c_TIMEOUT) wd_lost = 1'b1;
                if (!en) wd_lc = n - 1;
            end
            chk("tick_lost0", lost0, wd_lost, n);
            chk("tick_lost1", lost1, wd_lost, n);
`endif

            chk("pps0",     pps0,  pps_at(0, n),  n);
            chk("busy0",    busy0, busy_at(0, n), n);
            chk("overrun0", ovr0,  m_ovr[0],      n);
            chk("count0",   cnt0,  m_cnt[0],      n);
            chk("pps1",     pps1,  pps_at(1, n),  n);
            chk("busy1",    busy1, busy_at(1, n), n);
            chk("overrun1", ovr1,  m_ovr[1],      n);
            chk("count1",   cnt1,  m_cnt[1] % 16, n);

            // Next cycle's inputs; ticks are steered onto last-pulse / first-idle cycles.
            end0 = m_acc[0] + dly(0) + c_WCYC;
            end1 = m_acc[1] + dly(1) + c_WCYC;
            rst  = (n == 1) || ($urandom_range(0, 599) == 0);
            en   = ($urandom_range(0, 9) != 0);
            tick = ($urandom_range(0, 59) == 0);
            if ((n == end0) || (n == end0 + 1) || (n == end1) || (n == end1 + 1))
                tick = tick | ($urandom_range(0, 1) == 1);
            if ((n % 1500) > 1300) begin
                rst  = 1'b0;
                en   = 1'b1;
                tick = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
